// File: rtl/vote_collect_if.sv
// Voting bus between the ballot source (master) and vote_collect (slave).
// Carries the start/yes/no stimulus and the ballot/timer/status results.
interface vote_collect_if #(
    parameter int PERSON = 3
);
    logic              start;
    logic [PERSON-1:0] yes;
    logic [PERSON-1:0] no;
    logic [PERSON-1:0] in;
    logic [PERSON-1:0] voted;
    logic [7:0]        remain;
    logic              busy;
    logic              valid;

    modport master (
        output start, yes, no,
        input  in, voted, remain, busy, valid
    );

    modport slave (
        input  start, yes, no,
        output in, voted, remain, busy, valid
    );
endinterface

// File: rtl/vote_collect.sv
// vote_collect: opens a timed voting window on start, latches each voter's
// first unambiguous press (yes xor no), then holds the final ballot vector
// with valid=1 until the next start. Voters who never press count as reject.
// Optional macro VOTE_EARLY_CLOSE_EN: close the window one edge after every
// voter has cast a ballot instead of waiting for the timer.
module vote_collect #(
    parameter int PERSON = 3,
    parameter int WINDOW = 16
) (
    input  logic           clk,
    input  logic           reset,
    vote_collect_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        HOLD
    } state_t;

    localparam logic [7:0] WINDOW_CNT = 8'(WINDOW);

    state_t            state, state_nxt;
    logic [PERSON-1:0] ballot_q, ballot_d;
    logic [PERSON-1:0] voted_q, voted_d;
    logic [7:0]        remain_q, remain_d;
    logic [PERSON-1:0] press;

    // A press counts only for voters still open and only when exactly one
    // of yes/no is asserted; both-or-neither leaves the voter untouched.
    assign press = ~voted_q & (bus.yes ^ bus.no);

    // Next-state and datapath logic for the three-phase window.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_nxt = state;
        ballot_d  = ballot_q;
        voted_d   = voted_q;
        remain_d  = remain_q;
        case (state)
            IDLE, HOLD: begin
                if (bus.start) begin
                    state_nxt = COLLECT;
                    ballot_d  = '0;
                    voted_d   = '0;
                    remain_d  = WINDOW_CNT;
                end
            end
            COLLECT: begin
                // First press wins: only newly pressing voters update.
                ballot_d = (ballot_q & ~press) | (bus.yes & press);
                voted_d  = voted_q | press;
                remain_d = (remain_q != 8'd0) ? remain_q - 8'd1 : 8'd0;
                // The edge seen with remain==1 is the last sampling edge.
                if (remain_q <= 8'd1) begin
                    state_nxt = HOLD;
                    remain_d  = 8'd0;
                end
`ifdef VOTE_EARLY_CLOSE_EN
                // Everyone has voted: close now, whatever the timer says.
                if (&voted_q) begin
                    state_nxt = HOLD;
                    remain_d  = 8'd0;
                end
`else
`endif
                // start is deliberately ignored here; the window runs on.
            end
            default: begin
                state_nxt = IDLE;
                ballot_d  = '0;
                voted_d   = '0;
                remain_d  = 8'd0;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial window.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ballot_q <= '0;
            voted_q  <= '0;
            remain_q <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state    <= state_nxt;
            ballot_q <= ballot_d;
            voted_q  <= voted_d;
            remain_q <= remain_d;
        end
    end

    assign bus.in     = ballot_q;
    assign bus.voted  = voted_q;
    assign bus.remain = remain_q;
    assign bus.busy   = (state == COLLECT);
    assign bus.valid  = (state == HOLD);
endmodule

// File: tb/tb_vote_collect.sv
// Self-checking bench for vote_collect (PERSON=3, WINDOW=4). A behavioural
// model counts elapsed window edges and records first presses; a negedge
// process compares every output against it each cycle. Directed scenarios
// pin the model with literal expectations, then random traffic follows.
// Define VOTE_EARLY_CLOSE_EN for both bench and RTL to test early close.
module tb_vote_collect;
    localparam int P = 3;
    localparam int W = 4;
`ifdef VOTE_EARLY_CLOSE_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    vote_collect_if #(.PERSON(P)) bus ();

    vote_collect #(.PERSON(P), .WINDOW(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 window open, 2 result held.
    int             m_phase = 0;
    int             m_elapsed = 0;
    logic [P-1:0]   m_in = '0;
    logic [P-1:0]   m_voted = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase = 0; m_elapsed = 0; m_in = '0; m_voted = '0;
        end else if (m_phase == 1) begin
            if (EARLY && (m_voted == {P{1'b1}})) begin
                m_phase = 2;
            end else begin
                for (int i = 0; i < P; i++) begin
                    if (!m_voted[i] && (bus.yes[i] != bus.no[i])) begin
                        m_voted[i] = 1'b1;
                        m_in[i]    = bus.yes[i];
                    end
                end
                m_elapsed++;
                if (m_elapsed >= W) m_phase = 2;
            end
        end else if (bus.start) begin
            m_phase = 1; m_elapsed = 0; m_in = '0; m_voted = '0;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        check("cyc_in",     32'(bus.in),     32'(m_in));
        check("cyc_voted",  32'(bus.voted),  32'(m_voted));
        check("cyc_remain", 32'(bus.remain), (m_phase == 1) ? 32'(W - m_elapsed) : 32'd0);
        check("cyc_busy",   32'(bus.busy),   32'(m_phase == 1));
        check("cyc_valid",  32'(bus.valid),  32'(m_phase == 2));
    end

    task automatic cycle(input logic s, input logic [P-1:0] y, input logic [P-1:0] n);
        bus.start = s;
        bus.yes   = y;
        bus.no    = n;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [P-1:0] e_in, input logic [P-1:0] e_voted,
                              input logic [7:0] e_remain, input logic e_busy, input logic e_valid);
        check({tag, "_in"},     32'(bus.in),     32'(e_in));
        check({tag, "_voted"},  32'(bus.voted),  32'(e_voted));
        check({tag, "_remain"}, 32'(bus.remain), 32'(e_remain));
        check({tag, "_busy"},   32'(bus.busy),   32'(e_busy));
        check({tag, "_valid"},  32'(bus.valid),  32'(e_valid));
    endtask

    initial begin
        bus.start = 1'b0; bus.yes = '0; bus.no = '0;
        #2;
        expect_out("reset", 3'b000, 3'b000, 8'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        cycle(1'b0, 3'b000, 3'b000);
        expect_out("idle", 3'b000, 3'b000, 8'd0, 1'b0, 1'b0);

        // Reset mid-window after voter0 votes yes.
        cycle(1'b1, 3'b000, 3'b000);
        expect_out("open", 3'b000, 3'b000, 8'd4, 1'b1, 1'b0);
        cycle(1'b0, 3'b001, 3'b000);
        expect_out("v0yes", 3'b001, 3'b001, 8'd3, 1'b1, 1'b0);
        #1 reset = 1'b0;
        #1 expect_out("async_rst", 3'b000, 3'b000, 8'd0, 1'b0, 1'b0);
        #1 reset = 1'b1;
        cycle(1'b0, 3'b000, 3'b000);
        cycle(1'b0, 3'b000, 3'b000);
        expect_out("post_rst", 3'b000, 3'b000, 8'd0, 1'b0, 1'b0);

        // yes=101 on first window cycle only.
        cycle(1'b1, 3'b000, 3'b000);
        cycle(1'b0, 3'b101, 3'b000);
        cycle(1'b0, 3'b000, 3'b000);
        cycle(1'b0, 3'b000, 3'b000);
        expect_out("w101_last", 3'b101, 3'b101, 8'd1, 1'b1, 1'b0);
        cycle(1'b0, 3'b000, 3'b000);
        expect_out("w101_hold", 3'b101, 3'b101, 8'd0, 1'b0, 1'b1);
        cycle(1'b0, 3'b000, 3'b000);
        expect_out("w101_held", 3'b101, 3'b101, 8'd0, 1'b0, 1'b1);

        // First press wins; simultaneous yes&no is ignored.
        cycle(1'b1, 3'b000, 3'b000);
        cycle(1'b0, 3'b011, 3'b010);
        cycle(1'b0, 3'b010, 3'b011);
        cycle(1'b0, 3'b010, 3'b010);
        cycle(1'b0, 3'b010, 3'b010);
        expect_out("first_wins", 3'b001, 3'b001, 8'd0, 1'b0, 1'b1);

        // Everyone votes on cycle 1.
        cycle(1'b1, 3'b000, 3'b000);
        cycle(1'b0, 3'b011, 3'b100);
        cycle(1'b0, 3'b000, 3'b000);
        if (EARLY) begin
            expect_out("early", 3'b011, 3'b111, 8'd0, 1'b0, 1'b1);
        end else begin
            expect_out("no_early", 3'b011, 3'b111, 8'd2, 1'b1, 1'b0);
            cycle(1'b0, 3'b000, 3'b000);
            cycle(1'b0, 3'b000, 3'b000);
            expect_out("full_win", 3'b011, 3'b111, 8'd0, 1'b0, 1'b1);
        end

        // start ignored in COLLECT; start in HOLD reopens.
        cycle(1'b1, 3'b000, 3'b000);
        expect_out("reopen", 3'b000, 3'b000, 8'd4, 1'b1, 1'b0);
        cycle(1'b1, 3'b000, 3'b000);
        check("st_ign_3", 32'(bus.remain), 32'd3);
        cycle(1'b1, 3'b000, 3'b000);
        check("st_ign_2", 32'(bus.remain), 32'd2);
        cycle(1'b0, 3'b000, 3'b000);
        check("st_ign_1", 32'(bus.remain), 32'd1);
        cycle(1'b0, 3'b000, 3'b000);
        expect_out("abstain", 3'b000, 3'b000, 8'd0, 1'b0, 1'b1);
        cycle(1'b1, 3'b000, 3'b000);
        expect_out("hold_start", 3'b000, 3'b000, 8'd4, 1'b1, 1'b0);

        // Random traffic with occasional asynchronous resets.
        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom_range(0, 7) == 0), P'($urandom), P'($urandom));
            if ($urandom_range(0, 199) == 0) begin
                #1 reset = 1'b0;
                #1 reset = 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vote_collect.md
VOTE_COLLECT -- requirements
Module: vote_collect

Interface
REQ-001 SHALL have parameter PERSON, default 3: number of voters, range 1..16.
REQ-002 SHALL have parameter WINDOW, default 16: voting window length in clock cycles, range 1..255.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: request to open a new voting window.
REQ-006 SHALL have port yes, input, PERSON: per-voter "approve" button, sampled each cycle.
REQ-007 SHALL have port no, input, PERSON: per-voter "reject" button, sampled each cycle.
REQ-008 SHALL have port in, output, PERSON: final ballot vector; bit i = 1 approve, 0 reject or abstain; feeds the downstream majority decider.
REQ-009 SHALL have port voted, output, PERSON: bit i set once voter i has cast a ballot in the current window.
REQ-010 SHALL have port remain, output, 8: cycles left in the current window.
REQ-011 SHALL have port busy, output, 1: high while in COLLECT.
REQ-012 SHALL have port valid, output, 1: high while in HOLD; `in` is final and stable.

Function
REQ-013 SHALL implement three states: IDLE, COLLECT, HOLD.
REQ-014 IDLE: outputs at reset values; start=1 at edge N -> COLLECT from N+1, remain=WINDOW, voted=0, in=0.
REQ-015 COLLECT: each edge, per voter i with voted[i]=0: yes[i]=1 and no[i]=0 -> in[i]=1, voted[i]=1; no[i]=1 and yes[i]=0 -> in[i]=0, voted[i]=1; both or neither -> no change that cycle.
REQ-016 Ballots are first-press-wins: once voted[i]=1, further yes/no for voter i are ignored until the next window.
REQ-017 COLLECT: remain decrements by 1 per edge; at the edge where remain==1, the final sample is taken and the state moves to HOLD, so exactly WINDOW sampling edges occur.
REQ-018 Voters with voted[i]=0 at window close SHALL count as reject (in[i]=0).
REQ-019 HOLD: in, voted frozen; valid=1, busy=0, remain=0; held indefinitely.
REQ-020 HOLD with start=1 -> COLLECT next edge, same initialisation as REQ-014; valid drops in that same cycle.
REQ-021 start while in COLLECT SHALL be ignored; the window is not restarted.
REQ-022 remain SHALL never wrap below 0.
REQ-023 Early close, when enabled (REQ-027), takes priority over timer expiry occurring on the same edge; the resulting state is HOLD in either case.

Reset
REQ-024 reset=0 SHALL immediately, independent of clk, force state IDLE, in=0, voted=0, remain=0, busy=0, valid=0.
REQ-025 reset asserted mid-COLLECT SHALL discard all partial ballots; no HOLD is entered on release.
REQ-026 After reset release, the first edge with start=1 SHALL open a window per REQ-014.

Configuration
REQ-027 Macro VOTE_EARLY_CLOSE_EN defined: in COLLECT, once all PERSON bits of voted are 1 after an edge, the next edge SHALL enter HOLD regardless of remain.
REQ-028 Macro VOTE_EARLY_CLOSE_EN undefined: the window SHALL always run the full WINDOW cycles; voted reaching all-ones has no effect on timing.

Verification (PERSON=3, WINDOW=4)
REQ-029 Reset low mid-COLLECT after voter0 votes yes -> all outputs 0 asynchronously; after release, state IDLE, no valid.
REQ-030 start; yes=3'b101 on first window cycle, nothing after -> after 4 edges valid=1, in=3'b101, voted=3'b101.
REQ-031 start; yes[0] then no[0] on later cycle; yes[1]&no[1] together every cycle -> in=3'b001, voted=3'b001.
REQ-032 start; yes=3'b011 and no=3'b100 on cycle 1 -> with VOTE_EARLY_CLOSE_EN: valid on next edge, remain=0; without: valid after 4th edge, in=3'b011 either way.
REQ-033 start pulsed again during COLLECT -> remain continues 3,2,1, unaffected; start in HOLD -> busy=1, remain=4, voted=0, valid=0 next cycle.
